// File: rtl/config_pkg.sv
// Configuration package for the PMA lookup sequencer.
// It provides the subset of the core configuration that describes the
// physical memory attribute rule tables.
// Contents:
//   NrMaxRules     - capacity of every rule table
//   cva6_cfg_t     - rule counts plus base/length tables for three region kinds
//   cva6_cfg_empty - configuration with every table empty
package config_pkg;

    localparam int unsigned NrMaxRules = 16;

    typedef struct packed {
        int unsigned                    NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0]    NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0]    NonIdempotentLength;
        int unsigned                    NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0]    ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]    ExecuteRegionLength;
        int unsigned                    NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0]    CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]    CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/pma_lookup_seq.sv
// Sequential physical-memory-attribute lookup.
// A request address is latched, then the three rule tables are scanned one
// rule index per cycle; the accumulated region matches are returned as a
// single response held until the consumer takes it.
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   flush_i                 - abandon a scan in progress (no response)
//   req_valid_i/req_ready_o - request handshake, req_addr_i is the address
//   rsp_valid_o/rsp_ready_i - response handshake
//   rsp_nonidem_o/rsp_exec_o/rsp_cached_o - region attributes, 0 when idle
module pma_lookup_seq #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_nonidem_o,
    output logic        rsp_exec_o,
    output logic        rsp_cached_o
);

    function automatic int unsigned clamp_rules(input int unsigned n);
        return (n > config_pkg::NrMaxRules) ? config_pkg::NrMaxRules : n;
    endfunction

    // Region test in 65 bits so a region ending exactly at 2^64 cannot wrap.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] len);
        logic [64:0] top;
        top = {1'b0, base} + {1'b0, len};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < top);
    endfunction

    localparam int unsigned NI_CNT_I = clamp_rules(CVA6Cfg.NrNonIdempotentRules);
    localparam int unsigned EX_CNT_I = clamp_rules(CVA6Cfg.NrExecuteRegionRules);
    localparam int unsigned CA_CNT_I = clamp_rules(CVA6Cfg.NrCachedRegionRules);
    localparam int unsigned N_MAX_A  = (NI_CNT_I > EX_CNT_I) ? NI_CNT_I : EX_CNT_I;
    localparam int unsigned N_RULES  = (N_MAX_A > CA_CNT_I) ? N_MAX_A : CA_CNT_I;

    localparam logic [4:0] NI_CNT   = 5'(NI_CNT_I);
    localparam logic [4:0] EX_CNT   = 5'(EX_CNT_I);
    localparam logic [4:0] CA_CNT   = 5'(CA_CNT_I);
    // With no rules the scan still lasts exactly one cycle at index 0.
    localparam logic [3:0] LAST_IDX = (N_RULES == 0) ? 4'd0 : 4'(N_RULES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_r;
    logic [3:0]  idx_r;
    logic [63:0] addr_r;
    logic [2:0]  flags_r;      // {nonidem, exec, cached}
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [2:0]  rsp_attr_r;
    logic [2:0]  hit_s;
    logic [2:0]  flags_next_s;

    // Range checks of the rule at the current index, masked by each table's size.
    always_comb begin
        hit_s = 3'b000;
        if ({1'b0, idx_r} < NI_CNT) begin
            hit_s[2] = in_range(addr_r, CVA6Cfg.NonIdempotentAddrBase[idx_r],
                                CVA6Cfg.NonIdempotentLength[idx_r]);
        end else begin
            hit_s[2] = 1'b0;
        end
        if ({1'b0, idx_r} < EX_CNT) begin
            hit_s[1] = in_range(addr_r, CVA6Cfg.ExecuteRegionAddrBase[idx_r],
                                CVA6Cfg.ExecuteRegionLength[idx_r]);
        end else begin
            hit_s[1] = 1'b0;
        end
        if ({1'b0, idx_r} < CA_CNT) begin
            hit_s[0] = in_range(addr_r, CVA6Cfg.CachedRegionAddrBase[idx_r],
                                CVA6Cfg.CachedRegionLength[idx_r]);
        end else begin
            hit_s[0] = 1'b0;
        end
        flags_next_s = flags_r | hit_s;
    end

    // Lookup FSM with registered handshake and attribute outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            idx_r       <= 4'd0;
            addr_r      <= 64'd0;
            flags_r     <= 3'b000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_attr_r  <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_r      <= req_addr_i;
                        idx_r       <= 4'd0;
                        flags_r     <= 3'b000;
                        req_ready_r <= 1'b0;
                        state_r     <= SCAN;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                SCAN: begin
                    if (flush_i) begin
                        idx_r       <= 4'd0;
                        flags_r     <= 3'b000;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        flags_r <= flags_next_s;
                        idx_r   <= idx_r + 4'd1;
                        if (idx_r == LAST_IDX) begin
                            // Final rule folded in directly so the response
                            // carries this cycle's match as well.
                            rsp_attr_r  <= flags_next_s;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            state_r <= SCAN;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        rsp_attr_r  <= 3'b000;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    idx_r       <= 4'd0;
                    flags_r     <= 3'b000;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_attr_r  <= 3'b000;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_nonidem_o = rsp_attr_r[2];
    assign rsp_exec_o    = rsp_attr_r[1];
    assign rsp_cached_o  = rsp_attr_r[0];

endmodule

// File: tb/tb_pma_lookup_seq.sv
// Testbench for pma_lookup_seq: instance 0 uses a two/one/one rule table,
// instance 1 uses the empty configuration. A transaction-level model
// predicts handshakes and attributes every cycle; directed tests add
// literal expectations.
module tb_pma_lookup_seq;

    localparam logic [63:0] NI_BASE [2] = '{64'h0, 64'h1000_0000};
    localparam logic [63:0] NI_LEN  [2] = '{64'h1000, 64'h1000};
    localparam logic [63:0] EX_BASE = 64'h8000_0000;
    localparam logic [63:0] EX_LEN  = 64'h4000_0000;
    localparam logic [63:0] CA_BASE = 64'h8000_0000;
    localparam logic [63:0] CA_LEN  = 64'h4000_0000;

    function automatic config_pkg::cva6_cfg_t make_cfg();
        config_pkg::cva6_cfg_t c;
        c = config_pkg::cva6_cfg_empty;
        c.NrNonIdempotentRules     = 2;
        c.NonIdempotentAddrBase[0] = NI_BASE[0];
        c.NonIdempotentLength[0]   = NI_LEN[0];
        c.NonIdempotentAddrBase[1] = NI_BASE[1];
        c.NonIdempotentLength[1]   = NI_LEN[1];
        c.NrExecuteRegionRules     = 1;
        c.ExecuteRegionAddrBase[0] = EX_BASE;
        c.ExecuteRegionLength[0]   = EX_LEN;
        c.NrCachedRegionRules      = 1;
        c.CachedRegionAddrBase[0]  = CA_BASE;
        c.CachedRegionLength[0]    = CA_LEN;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t TB_CFG = make_cfg();

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush [2];
    logic        req_valid [2];
    logic [63:0] req_addr [2];
    logic        rsp_ready [2];
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_nonidem;
    logic [1:0]  rsp_exec;
    logic [1:0]  rsp_cached;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pma_lookup_seq #(.CVA6Cfg(TB_CFG)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_nonidem_o(rsp_nonidem[0]), .rsp_exec_o(rsp_exec[0]), .rsp_cached_o(rsp_cached[0])
    );

    pma_lookup_seq #(.CVA6Cfg(config_pkg::cva6_cfg_empty)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_nonidem_o(rsp_nonidem[1]), .rsp_exec_o(rsp_exec[1]), .rsp_cached_o(rsp_cached[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic inr(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
        logic [64:0] top;
        top = {1'b0, b} + {1'b0, l};
        return ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < top);
    endfunction

    // Attributes {nonidem, exec, cached}; instance 1 has no rules at all.
    function automatic logic [2:0] classify(input int d, input logic [63:0] a);
        logic [2:0] r;
        r = 3'b000;
        if (d == 0) begin
            for (int i = 0; i < 2; i++) r[2] = r[2] | inr(a, NI_BASE[i], NI_LEN[i]);
            r[1] = inr(a, EX_BASE, EX_LEN);
            r[0] = inr(a, CA_BASE, CA_LEN);
        end
        return r;
    endfunction

    // Response latency: largest table size, at least one cycle.
    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    logic [1:0] m_ready;
    logic [1:0] m_scan;
    logic [1:0] m_pend;
    int         m_cnt [2];
    logic [2:0] m_attr [2];

    // Transaction model: accept, count down the scan, hold until consumed.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_ready <= 2'b11;
            m_scan  <= 2'b00;
            m_pend  <= 2'b00;
            for (int d = 0; d < 2; d++) begin
                m_cnt[d]  <= 0;
                m_attr[d] <= 3'b000;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_ready[d]) begin
                    if (req_valid[d]) begin
                        m_ready[d] <= 1'b0;
                        m_scan[d]  <= 1'b1;
                        m_cnt[d]   <= lat_of(d);
                        m_attr[d]  <= classify(d, req_addr[d]);
                    end
                end else if (m_scan[d]) begin
                    if (flush[d]) begin
                        m_scan[d]  <= 1'b0;
                        m_ready[d] <= 1'b1;
                    end else if (m_cnt[d] == 1) begin
                        m_scan[d] <= 1'b0;
                        m_pend[d] <= 1'b1;
                    end else begin
                        m_cnt[d] <= m_cnt[d] - 1;
                    end
                end else if (m_pend[d] && rsp_ready[d]) begin
                    m_pend[d]  <= 1'b0;
                    m_ready[d] <= 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_ready%0d", d), 64'(req_ready[d]), 64'(m_ready[d]));
            check($sformatf("model_valid%0d", d), 64'(rsp_valid[d]), 64'(m_pend[d]));
            check($sformatf("model_attr%0d", d),
                  64'({rsp_nonidem[d], rsp_exec[d], rsp_cached[d]}),
                  64'(m_pend[d] ? m_attr[d] : 3'b000));
        end
    end

    task automatic send(input int d, input logic [63:0] a);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = ~a;
    endtask

    task automatic wait_rsp(input int d, input int exp_lat, input logic [2:0] exp_attr, input string nm);
        int lat;
        lat = 0;
        while (!rsp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_attr"}, 64'({rsp_nonidem[d], rsp_exec[d], rsp_cached[d]}), 64'(exp_attr));
    endtask

    task automatic consume(input int d, input string nm);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check({nm, "_ready_after"}, 64'(req_ready[d]), 64'd1);
        check({nm, "_valid_after"}, 64'(rsp_valid[d]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = 64'd0; rsp_ready[d] = 1'b0;
        end
        #12;
        check("reset_ready", 64'(req_ready), 64'h3);
        check("reset_valid", 64'(rsp_valid), 64'h0);
        check("reset_attr", 64'({rsp_nonidem, rsp_exec, rsp_cached}), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        send(0, 64'h8000_0010);          wait_rsp(0, 2, 3'b011, "exec_cached"); consume(0, "exec_cached");
        send(0, 64'h1000_0FFF);          wait_rsp(0, 2, 3'b100, "ni_top");      consume(0, "ni_top");
        send(0, 64'h1000_1000);          wait_rsp(0, 2, 3'b000, "ni_excl");     consume(0, "ni_excl");
        send(0, 64'h0);                  wait_rsp(0, 2, 3'b100, "ni_zero");     consume(0, "ni_zero");
        send(0, 64'hBFFF_FFFF);          wait_rsp(0, 2, 3'b011, "ex_top");      consume(0, "ex_top");
        send(0, 64'h7FFF_FFFF);          wait_rsp(0, 2, 3'b000, "ex_below");    consume(0, "ex_below");

        // Stalled response must hold; flush is ignored while a response waits.
        send(0, 64'h8000_0010);
        wait_rsp(0, 2, 3'b011, "stall");
        flush[0] = 1'b1;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(rsp_valid[0]), 64'd1);
            check("stall_ready", 64'(req_ready[0]), 64'd0);
            check("stall_attr", 64'({rsp_nonidem[0], rsp_exec[0], rsp_cached[0]}), 64'h3);
        end
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        consume(0, "stall");

        // Flush in the first scan cycle abandons the lookup.
        send(0, 64'h8000_0010);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        check("flush_ready", 64'(req_ready[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_rsp", 64'(rsp_valid[0]), 64'd0);
        end
        send(0, 64'hC000_0000);          wait_rsp(0, 2, 3'b000, "after_flush"); consume(0, "after_flush");

        // Reset mid-scan: immediate idle outputs, no stale response.
        send(0, 64'h8000_0010);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_ready", 64'(req_ready[0]), 64'd1);
        check("rst_mid_valid", 64'(rsp_valid[0]), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(rsp_valid[0]), 64'd0);
        end
        send(0, 64'h1000_0000);          wait_rsp(0, 2, 3'b100, "after_rst");   consume(0, "after_rst");

        // Empty tables: one-cycle scan, no match even at the top of memory.
        send(1, 64'hFFFF_FFFF_FFFF_FFFF); wait_rsp(1, 1, 3'b000, "empty_top");  consume(1, "empty_top");
        send(1, 64'h8000_0010);          wait_rsp(1, 1, 3'b000, "empty_exec");  consume(1, "empty_exec");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
